// File: rtl/param_counter.sv
// Parametrised up/down modulo counter with enable prescaler, synchronous load,
// wrap or saturate at the limits, and a one-clock terminal-count pulse.
module param_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_VALUE = (2 ** WIDTH) - 1,
  parameter int          PRESCALE  = 1,
  parameter int          SATURATE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VALUE);
  localparam logic             SAT_C    = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tc_q, tc_d;

  // Next-state: load beats step beats hold; tc only marks a step taken at a limit
  always_comb begin
    count_d = count_q;
    psc_d   = psc_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
      psc_d   = '0;
    end else if (enable) begin
      if (psc_q == PSC_LAST) begin
        psc_d = '0;
        if (up_down) begin
          if (count_q == MAX_C) begin
            tc_d    = 1'b1;
            count_d = SAT_C ? count_q : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            tc_d    = 1'b1;
            count_d = SAT_C ? count_q : MAX_C;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end
    end else begin
      count_d = count_q;
      psc_d   = psc_q;
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      psc_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      tc_q    <= tc_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign at_max = (count_q == MAX_C);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_param_counter.sv
// Three counter configurations (wrap, saturate, prescale-by-3) driven in
// parallel and checked against an arithmetic reference model.
module tb_param_counter;

  localparam int MAXV = 9;
  localparam int P_A [3] = '{1, 1, 3};
  localparam int S_A [3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, ud = 1'b1, ld = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [3:0] count_w, count_s, count_p;
  logic       tc_w, tc_s, tc_p, amax_w, amax_s, amax_p, amin_w, amin_s, amin_p;
  logic [3:0] cnt_a [3];
  logic       tc_a [3], amax_a [3], amin_a [3];

  int  m_cnt [3];
  int  m_psc [3];
  bit  m_tc [3];
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(0)) dut_w (
    .clock(clk), .reset(rst_n), .enable(en), .up_down(ud), .load(ld), .load_value(lv),
    .count(count_w), .tc(tc_w), .at_max(amax_w), .at_min(amin_w));
  param_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(1)) dut_s (
    .clock(clk), .reset(rst_n), .enable(en), .up_down(ud), .load(ld), .load_value(lv),
    .count(count_s), .tc(tc_s), .at_max(amax_s), .at_min(amin_s));
  param_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3), .SATURATE(0)) dut_p (
    .clock(clk), .reset(rst_n), .enable(en), .up_down(ud), .load(ld), .load_value(lv),
    .count(count_p), .tc(tc_p), .at_max(amax_p), .at_min(amin_p));

  assign cnt_a[0] = count_w;  assign cnt_a[1] = count_s;  assign cnt_a[2] = count_p;
  assign tc_a[0] = tc_w;      assign tc_a[1] = tc_s;      assign tc_a[2] = tc_p;
  assign amax_a[0] = amax_w;  assign amax_a[1] = amax_s;  assign amax_a[2] = amax_p;
  assign amin_a[0] = amin_w;  assign amin_a[1] = amin_s;  assign amin_a[2] = amin_p;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_psc[k] = 0; m_tc[k] = 1'b0;
    end
  endtask

  // One rising edge of the reference: counting expressed as modular / clamped arithmetic
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      m_tc[k] = 1'b0;
      if (ld) begin
        m_cnt[k] = (int'(lv) > MAXV) ? MAXV : int'(lv);
        m_psc[k] = 0;
      end else if (en) begin
        m_psc[k] = (m_psc[k] + 1) % P_A[k];
        if (m_psc[k] == 0) begin
          m_tc[k] = ud ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0);
          if (S_A[k] != 0)
            m_cnt[k] = ud ? ((m_cnt[k] + 1 > MAXV) ? MAXV : m_cnt[k] + 1)
                          : ((m_cnt[k] - 1 < 0) ? 0 : m_cnt[k] - 1);
          else
            m_cnt[k] = ud ? (m_cnt[k] + 1) % (MAXV + 1) : (m_cnt[k] + MAXV) % (MAXV + 1);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; ud = 1'b1; ld = 1'b0;
    #2;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({cnt_a[k], tc_a[k], amax_a[k], amin_a[k]} !== 7'b0000_0_0_1) begin
        failures++;
        $display("FAIL reset inst%0d got cnt=%0d tc=%b max=%b min=%b want cnt=0 tc=0 max=0 min=1",
                 k, cnt_a[k], tc_a[k], amax_a[k], amin_a[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_count(input logic dir, input int n, input string name);
    do_reset();
    en = 1'b1; ud = dir; ld = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({cnt_a[k], tc_a[k], amax_a[k], amin_a[k]} !==
            {4'(m_cnt[k]), m_tc[k], m_cnt[k] == MAXV, m_cnt[k] == 0}) begin
          failures++;
          $display("FAIL %s inst%0d step%0d got cnt=%0d tc=%b max=%b min=%b want cnt=%0d tc=%b",
                   name, k, i, cnt_a[k], tc_a[k], amax_a[k], amin_a[k], m_cnt[k], m_tc[k]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    en = 1'b1; ud = 1'b1; ld = 1'b1; lv = 4'd7;
    for (int i = 0; i < 7; i++) begin
      cyc();
      ld = 1'b0;
      if (i == 5) ud = 1'b0;
      checks++;
      if ({count_s, tc_s} !== {4'(m_cnt[1]), m_tc[1]}) begin
        failures++;
        $display("FAIL saturate step%0d got cnt=%0d tc=%b want cnt=%0d tc=%b",
                 i, count_s, tc_s, m_cnt[1], m_tc[1]);
      end
    end
    checks++;
    if ({count_s, tc_s} !== {4'd8, 1'b0}) begin
      failures++;
      $display("FAIL saturate_final got cnt=%0d tc=%b want cnt=8 tc=0", count_s, tc_s);
    end
  endtask

  task automatic test_prescale();
    do_reset();
    en = 1'b1; ud = 1'b1; ld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = (i >= 4 && i < 8) ? 1'b0 : 1'b1;
      cyc();
      checks++;
      if ({count_p, tc_p} !== {4'(m_cnt[2]), m_tc[2]}) begin
        failures++;
        $display("FAIL prescale clk%0d got cnt=%0d tc=%b want cnt=%0d tc=%b",
                 i, count_p, tc_p, m_cnt[2], m_tc[2]);
      end
    end
  endtask

  task automatic test_load_clamp();
    do_reset();
    en = 1'b1; ud = 1'b1; ld = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      ld = (i < 2); en = (i != 1); lv = (i == 0) ? 4'd15 : 4'd3;
      cyc();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({cnt_a[k], tc_a[k]} !== {4'(m_cnt[k]), m_tc[k]} ||
            (i == 0 && cnt_a[k] !== 4'd9) || (i == 1 && cnt_a[k] !== 4'd3)) begin
          failures++;
          $display("FAIL load_clamp inst%0d op%0d got cnt=%0d tc=%b want cnt=%0d tc=%b",
                   k, i, cnt_a[k], tc_a[k], m_cnt[k], m_tc[k]);
        end
      end
    end
    ld = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; ud = 1'b1; ld = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({cnt_a[k], tc_a[k], amin_a[k]} !== {4'd0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL async_reset inst%0d got cnt=%0d tc=%b want cnt=0 tc=0", k, cnt_a[k], tc_a[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({count_w, count_p} !== {4'd1, 4'd0}) begin
      failures++;
      $display("FAIL async_resume got w=%0d p=%0d want w=1 p=0", count_w, count_p);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(3) != 0);
      ud = $urandom_range(1);
      ld = ($urandom_range(7) == 0);
      lv = 4'($urandom_range(15));
      cyc();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({cnt_a[k], tc_a[k], amax_a[k], amin_a[k]} !==
            {4'(m_cnt[k]), m_tc[k], m_cnt[k] == MAXV, m_cnt[k] == 0}) begin
          failures++;
          $display("FAIL random inst%0d cyc%0d got cnt=%0d tc=%b want cnt=%0d tc=%b",
                   k, i, cnt_a[k], tc_a[k], m_cnt[k], m_tc[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count(1'b1, 14, "count_up");
    test_count(1'b0, 14, "count_down");
    test_saturate();
    test_prescale();
    test_load_clamp();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
